// File: rtl/serial_word_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_deserializer_pkg
// Description : Shared direction encoding and FSM state type for the
//               serial word deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_word_deserializer_pkg;

    // Same encoding as the universal shift register's shift modes.
    localparam logic DIR_SHR = 1'b0;
    localparam logic DIR_SHL = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage : serial_word_deserializer_pkg
`default_nettype wire

// File: rtl/serial_word_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_deserializer_if
// Description : Serial input stream plus parallel word valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_word_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_valid;
    logic             dir;
    logic             abort;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             overrun;
    logic             clr_overrun;
    logic             busy;

    modport master (
        output sin, sin_valid, dir, abort, word_ready, clr_overrun,
        input  word_out, word_valid, overrun, busy
    );

    modport slave (
        input  sin, sin_valid, dir, abort, word_ready, clr_overrun,
        output word_out, word_valid, overrun, busy
    );
endinterface : serial_word_deserializer_if
`default_nettype wire

// File: rtl/serial_word_deserializer_hold.sv
`default_nettype none
// ============================================================================
// Module      : deser_hold_reg
// Description : Single-entry valid/ready holding register with sticky
//               overrun flag for words that find it occupied.
// Revision    : 1.0 - initial release
// ============================================================================
module deser_hold_reg #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_data,
    input  wire logic             ready,
    input  wire logic             clr_overrun,
    output logic      [WIDTH-1:0] data,
    output logic                  valid,
    output logic                  overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             w_xfer;
    logic             w_can_load;

    assign w_xfer     = r_valid & ready;
    // A word leaving this cycle frees the slot for a word arriving this cycle.
    assign w_can_load = ~r_valid | ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (load && w_can_load) begin
                r_data  <= load_data;
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end

            if (load && !w_can_load) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign data    = r_data;
    assign valid   = r_valid;
    assign overrun = r_overrun;

endmodule : deser_hold_reg
`default_nettype wire

// File: rtl/serial_word_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_deserializer
// Description : Rebuilds WIDTH-bit words from a serial shift stream in
//               either direction and hands them off through a holding reg.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_deserializer
    import serial_word_deserializer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH)
) (
    input wire logic                  clk,
    input wire logic                  rst,
    serial_word_deserializer_if.slave bus
);

    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_sr;
    logic             r_frame_dir;

    logic             w_accept;
    logic             w_dir;
    logic             w_last;
    logic [WIDTH-1:0] w_sr_next;
    logic [WIDTH-1:0] w_hold_data;
    logic             w_hold_valid;
    logic             w_hold_overrun;

    assign w_accept = bus.sin_valid & ~bus.abort;
    // The first bit of a frame uses the live dir; later bits use the latched one.
    assign w_dir    = (r_state == ST_IDLE) ? bus.dir : r_frame_dir;
    assign w_last   = w_accept && (r_count == C_LAST);

    always_comb begin
        w_sr_next = r_sr;
        if (w_dir == DIR_SHR) begin
            w_sr_next = {bus.sin, r_sr[WIDTH-1:1]};
        end else begin
            w_sr_next = {r_sr[WIDTH-2:0], bus.sin};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_sr        <= '0;
            r_frame_dir <= DIR_SHR;
        end else if (bus.abort) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else if (bus.sin_valid) begin
            r_sr <= w_sr_next;
            if (r_state == ST_IDLE) begin
                r_frame_dir <= bus.dir;
            end
            if (w_last) begin
                r_state <= ST_IDLE;
                r_count <= '0;
            end else begin
                r_state <= ST_SHIFT;
                r_count <= r_count + CW'(1);
            end
        end
    end

    deser_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk         (clk),
        .rst         (rst),
        .load        (w_last),
        .load_data   (w_sr_next),
        .ready       (bus.word_ready),
        .clr_overrun (bus.clr_overrun),
        .data        (w_hold_data),
        .valid       (w_hold_valid),
        .overrun     (w_hold_overrun)
    );

    assign bus.word_out   = w_hold_data;
    assign bus.word_valid = w_hold_valid;
    assign bus.overrun    = w_hold_overrun;
    assign bus.busy       = (r_state == ST_SHIFT);

endmodule : serial_word_deserializer
`default_nettype wire

// File: tb/tb_serial_word_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_deserializer
// Description : Self-checking bench with a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_deserializer;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Levels applied on every cycle for the consumer side.
    logic rdy = 1'b1;
    logic clr = 1'b0;

    // Reference model: pending frame bits plus holding register contents.
    logic             q[$];
    logic             mdir;
    logic [WIDTH-1:0] exp_word;
    logic             exp_valid;
    logic             exp_ovr;

    serial_word_deserializer_if #(.WIDTH(WIDTH)) bus ();

    serial_word_deserializer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic r, input logic s, input logic sv,
                         input logic d, input logic ab);
        logic [WIDTH-1:0] w;
        logic             done;
        rst             = r;
        bus.sin         = s;
        bus.sin_valid   = sv;
        bus.dir         = d;
        bus.abort       = ab;
        bus.word_ready  = rdy;
        bus.clr_overrun = clr;
        @(posedge clk);
        done = 1'b0;
        w    = '0;
        if (r) begin
            q.delete();
            exp_word  = '0;
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
        end else begin
            if (ab) begin
                q.delete();
            end else if (sv) begin
                if (q.size() == 0) mdir = d;
                q.push_back(s);
                if (q.size() == WIDTH) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (mdir == 1'b0) w[i] = q[i];
                        else              w[WIDTH-1-i] = q[i];
                    end
                    q.delete();
                    done = 1'b1;
                end
            end
            if (done && exp_valid && !rdy) begin
                exp_ovr = 1'b1;
            end else begin
                if (done) begin
                    exp_word  = w;
                    exp_valid = 1'b1;
                end else if (exp_valid && rdy) begin
                    exp_valid = 1'b0;
                end
                if (clr) exp_ovr = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] bits, input logic d);
        // bits[WIDTH-1] is sent first
        for (int i = WIDTH - 1; i >= 0; i--) cycle(1'b0, bits[i], 1'b1, d, 1'b0);
    endtask

    task automatic test_reset();
        rdy = 1'b0;
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.word_out !== 4'b0000 || bus.word_valid !== 1'b0 ||
            bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: out=%b valid=%b ovr=%b busy=%b required all 0",
                     bus.word_out, bus.word_valid, bus.overrun, bus.busy);
        end
    endtask

    task automatic test_shr();
        logic [3:0] bits;
        bits = 4'b1011;
        rdy  = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            cycle(1'b0, bits[i], 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.busy !== (i != 0)) begin
                errors++;
                $display("FAIL shr_busy bit%0d: busy=%b required %b", 3 - i, bus.busy, i != 0);
            end
            checks++;
            if (bus.word_valid !== (i == 0)) begin
                errors++;
                $display("FAIL shr_latency bit%0d: valid=%b required %b", 3 - i, bus.word_valid, i == 0);
            end
        end
        checks++;
        if (bus.word_out !== 4'b1101 || exp_word !== 4'b1101) begin
            errors++;
            $display("FAIL shr_word: out=%b required 1101", bus.word_out);
        end
        rdy = 1'b1;
        idle(1);
        checks++;
        if (bus.word_valid !== 1'b0) begin
            errors++;
            $display("FAIL shr_drain: valid=%b required 0", bus.word_valid);
        end
    endtask

    task automatic test_shl_dir_flip();
        rdy = 1'b0;
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.word_out !== 4'b1011 || bus.word_valid !== 1'b1) begin
            errors++;
            $display("FAIL shl_flip: out=%b valid=%b required 1011 1", bus.word_out, bus.word_valid);
        end
        rdy = 1'b1;
        idle(1);
    endtask

    task automatic test_gaps();
        logic [3:0] bits;
        bits = 4'b1011;
        rdy  = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            cycle(1'b0, bits[i], 1'b1, 1'b0, 1'b0);
            if (i != 0) begin
                idle(3);
                checks++;
                if (bus.busy !== 1'b1 || bus.word_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_hold bit%0d: busy=%b valid=%b required 1 0",
                             3 - i, bus.busy, bus.word_valid);
                end
            end
        end
        checks++;
        if (bus.word_out !== 4'b1101 || bus.word_valid !== 1'b1) begin
            errors++;
            $display("FAIL gap_word: out=%b valid=%b required 1101 1", bus.word_out, bus.word_valid);
        end
        rdy = 1'b1;
        idle(1);
    endtask

    task automatic test_overrun();
        rdy = 1'b0;
        send_word(4'b0101, 1'b1);
        send_word(4'b0011, 1'b1);
        checks++;
        if (bus.word_out !== 4'b0101 || bus.overrun !== 1'b1 || bus.word_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: out=%b ovr=%b valid=%b required 0101 1 1",
                     bus.word_out, bus.overrun, bus.word_valid);
        end
        rdy = 1'b1;
        idle(1);
        checks++;
        if (bus.word_valid !== 1'b0 || bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_drain: valid=%b ovr=%b required 0 1", bus.word_valid, bus.overrun);
        end
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        checks++;
        if (bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: ovr=%b required 0", bus.overrun);
        end
    endtask

    task automatic test_back_to_back();
        rdy = 1'b0;
        send_word(4'b1001, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        rdy = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        rdy = 1'b0;
        checks++;
        if (bus.word_out !== 4'b0110 || bus.word_valid !== 1'b1 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: out=%b valid=%b ovr=%b required 0110 1 0",
                     bus.word_out, bus.word_valid, bus.overrun);
        end
        rdy = 1'b1;
        idle(1);
    endtask

    task automatic test_abort_rst();
        rdy = 1'b0;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: busy=%b required 0", bus.busy);
        end
        send_word(4'b0111, 1'b1);
        checks++;
        if (bus.word_out !== 4'b0111 || bus.word_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_word: out=%b valid=%b required 0111 1", bus.word_out, bus.word_valid);
        end
        rdy = 1'b1;
        idle(1);
        rdy = 1'b0;
        // abort on the completing bit must win
        send_word(4'b1100, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.word_out !== 4'b0011 || bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_priority: out=%b ovr=%b busy=%b required 0011 0 0",
                     bus.word_out, bus.overrun, bus.busy);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.word_out !== 4'b0000 || bus.word_valid !== 1'b0 ||
            bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: out=%b valid=%b ovr=%b busy=%b required all 0",
                     bus.word_out, bus.word_valid, bus.overrun, bus.busy);
        end
    endtask

    task automatic test_random();
        logic r, s, sv, d, ab;
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            s   = 1'($urandom);
            sv  = ($urandom_range(0, 3) != 0);
            d   = 1'($urandom);
            ab  = ($urandom_range(0, 29) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 9) == 0);
            cycle(r, s, sv, d, ab);
            checks++;
            if (bus.word_valid !== exp_valid || bus.overrun !== exp_ovr ||
                bus.busy !== (q.size() != 0) || (exp_valid && bus.word_out !== exp_word)) begin
                errors++;
                $display("FAIL random cyc%0d: out=%b valid=%b ovr=%b busy=%b required %b %b %b %b",
                         n, bus.word_out, bus.word_valid, bus.overrun, bus.busy,
                         exp_word, exp_valid, exp_ovr, q.size() != 0);
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        mdir      = 1'b0;
        exp_word  = '0;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        test_reset();
        test_shr();
        test_shl_dir_flip();
        test_gaps();
        test_overrun();
        test_back_to_back();
        test_abort_rst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_word_deserializer
`default_nettype wire

// File: doc/serial_word_deserializer.md
Name: serial_word_deserializer

Overview:
- Receive end of the universal shift register's serial shift path. Collects WIDTH serial bits emitted from the MSB/LSB end of a shifting register and rebuilds the parallel word.
- Supports both shift directions, a per-bit qualifier, abort of a partial frame, and a single-entry output holding register with valid/ready handshake.
- Reports overrun when a completed word finds the holding register still occupied.

Parameters:
- WIDTH, 4, word length in bits (>=2); matches the 4-bit universal shift register.
- CW, $clog2(WIDTH), bit-counter width.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- sin  input  1  serial data bit
- sin_valid  input  1  sin is a valid bit this cycle
- dir  input  1  0 = shift-right stream (first bit ends at LSB), 1 = shift-left stream (first bit ends at MSB)
- abort  input  1  discard partial frame
- word_out  output  WIDTH  assembled word, stable while word_valid=1
- word_valid  output  1  holding register full
- word_ready  input  1  consumer accepts word_out
- overrun  output  1  sticky: a completed word was dropped
- clr_overrun  input  1  clears overrun
- busy  output  1  partial frame in progress (count != 0)

Behaviour:
- Reset (rst=1 at clk edge): shift reg=0, count=0, FSM=IDLE, word_out=0, word_valid=0, overrun=0, busy=0. Reset mid-frame discards everything, including the holding register.
- FSM states: IDLE (count=0) and SHIFT (1..WIDTH-1 bits held).
- IDLE -> SHIFT: sin_valid=1 and abort=0. dir is latched into frame_dir on this bit and used for the whole frame. dir changes mid-frame are ignored.
- Shift rule, frame_dir=0: sr <= {sin, sr[WIDTH-1:1]}.
- Shift rule, frame_dir=1: sr <= {sr[WIDTH-2:0], sin}.
- Each accepted bit increments count. No valid bit means count and sr hold; gaps of any length are allowed.
- Frame completion: on the bit with count=WIDTH-1, the assembled word (including that bit) goes to the holding register. count wraps to 0, FSM returns to IDLE, and the next bit may arrive the very next cycle.
- Latency: word_valid rises the cycle after the last bit is accepted.
- Handshake: word transfers on word_valid & word_ready. word_valid falls the next cycle unless a new word loads in that same cycle.
- Completion while holding empty, or full but word_ready=1 that cycle: new word loads, word_valid=1, no overrun.
- Completion while full and word_ready=0: new word dropped, old word kept, overrun<=1.
- overrun is cleared only by clr_overrun or rst. If clr_overrun and a new overrun occur in the same cycle, set wins.
- abort=1: count<=0, FSM<=IDLE. A sin_valid bit in the same cycle is discarded. The holding register and overrun are unaffected. abort has priority over frame completion.
- busy = (FSM==SHIFT).

Decomposition:
- Shared package: dir encoding constants (DIR_SHR=1'b0, DIR_SHL=1'b1, the same encoding used for the universal register's shift modes) and the FSM state enum (ST_IDLE, ST_SHIFT).
- One natural sub-module: deser_hold_reg, a single-entry valid/ready holding register with a load input and an overrun flag. The top level holds the FSM, counter and shift register.

Test Plan:
- WIDTH=4, reset then dir=0, bits 1,0,1,1 on consecutive cycles -> word_out=4'b1101, word_valid=1 one cycle after the 4th bit; busy high for cycles 2-4.
- dir=1, bits 1,0,1,1 -> word_out=4'b1011. Flipping dir to 0 after the 2nd bit still gives 4'b1011.
- Same bits with sin_valid low for 3 cycles between each bit -> identical word, count holds during gaps.
- word_ready=0: send 0101 then 0011 -> word_out stays 4'b0101 and overrun=1. Then word_ready=1 -> 0101 transferred, word_valid=0. clr_overrun -> overrun=0.
- Back-to-back: word_ready=1 exactly in the cycle the 2nd word completes -> 1st word transferred, 2nd word loaded, word_valid stays 1, overrun=0.
- abort after 2 bits, then 4 bits 1,1,1,0 (dir=0) -> word_out=4'b0111. rst asserted after 3 bits of another frame -> all outputs 0 next cycle.
